// File: rtl/fc_seq_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
package fc_seq_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        CLASS  = 2'd3
    } seq_state_e;

    localparam int ST_CNT_W   = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    function automatic int acc_width(input int width, input int n_in);
        return width * 2 + $clog2(n_in);
    endfunction

    // Never narrower than one bit, so single-entry counters still have a register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit settle_ok(input int cyc);
        return (cyc >= SETTLE_MIN) && (cyc <= SETTLE_MAX);
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_argmax.sv
// Running argmax over the emitted neuron results; a tie keeps the lower index.
module argmax_tracker
    import fc_seq_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             upd,
    input  logic [ACC_W-1:0] val,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] max_idx
);

    logic [ACC_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] arg_q, arg_d;

    always_comb begin
        max_d = max_q;
        arg_d = arg_q;
        if (clear) begin
            max_d = '0;
            arg_d = '0;
        end else if (upd && ((idx == '0) || (val > max_q))) begin
            max_d = val;
            arg_d = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_d;
            arg_q <= arg_d;
        end
    end

    assign max_idx = arg_q;

endmodule

// File: rtl/fc_layer_sequencer.sv
// Loads an activation vector, holds it for the neuron tree to settle, then
// streams the OUT results (valid/ready) and reports the argmax class.
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IN         = 128,
    parameter int OUT        = 10,
    parameter int SETTLE_CYC = 2,
    parameter int ACC_W      = acc_width(WIDTH, IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic [WIDTH-1:0]             x [0:IN-1],
    input  logic [ACC_W-1:0]             z_in [0:OUT-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic [idx_width(OUT)-1:0]    out_idx,
    output logic                         out_last,
    output logic                         class_valid,
    output logic [idx_width(OUT)-1:0]    class_idx,
    output logic                         busy
);

    localparam int IDX_W = idx_width(OUT);
    localparam int LD_W  = idx_width(IN);

    if (!settle_ok(SETTLE_CYC)) begin : g_settle_range
        $error("SETTLE_CYC must lie in 1..15");
    end

    seq_state_e          state_q, state_d;
    logic [LD_W-1:0]     ld_cnt_q, ld_cnt_d;
    logic [ST_CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [IDX_W-1:0]    class_idx_q, class_idx_d;
    logic [WIDTH-1:0]    x_q [0:IN-1];
    logic [WIDTH-1:0]    x_d [0:IN-1];

    logic [IDX_W-1:0] idx_nxt;
    logic             last_beat;
    logic             hs;
    logic [IDX_W-1:0] max_idx;

    assign idx_nxt   = idx_q + IDX_W'(1);
    assign last_beat = (idx_q == IDX_W'(OUT - 1));
    assign hs        = (state_q == EMIT) && out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        st_cnt_d    = st_cnt_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        class_idx_d = class_idx_q;
        x_d         = x_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    x_d[ld_cnt_q] = in_data;
                    if (ld_cnt_q == LD_W'(IN - 1)) begin
                        ld_cnt_d = '0;
                        st_cnt_d = ST_CNT_W'(SETTLE_CYC - 1);
                        state_d  = SETTLE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LD_W'(1);
                    end
                end
            end
            SETTLE: begin
                // The tree has seen a stable x for SETTLE_CYC cycles once st_cnt hits 0.
                if (st_cnt_q == '0) begin
                    out_data_d  = z_in[0];
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = EMIT;
                end else begin
                    st_cnt_d = st_cnt_q - ST_CNT_W'(1);
                end
            end
            EMIT: begin
                if (hs) begin
                    if (last_beat) begin
                        out_valid_d = 1'b0;
                        state_d     = CLASS;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = z_in[idx_nxt];
                    end
                end
            end
            CLASS: begin
                class_idx_d = max_idx;
                ld_cnt_d    = '0;
                idx_d       = '0;
                state_d     = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            class_idx_q <= '0;
            for (int i = 0; i < IN; i++) x_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            st_cnt_q    <= st_cnt_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            class_idx_q <= class_idx_d;
            x_q         <= x_d;
        end
    end

    argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == SETTLE),
        .upd     (hs),
        .val     (out_data_q),
        .idx     (idx_q),
        .max_idx (max_idx)
    );

    assign x           = x_q;
    assign in_ready    = (state_q == LOAD);
    assign busy        = (state_q != LOAD);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_idx     = idx_q;
    assign out_last    = out_valid_q && last_beat;
    assign class_valid = (state_q == CLASS);
    // During the pulse the tracker already holds the final arg; afterwards the latched copy.
    assign class_idx   = class_valid ? max_idx : class_idx_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized self-checking bench for fc_layer_sequencer with a behavioural neuron model.
module tb_fc_layer_sequencer;

    localparam int WIDTH      = 8;
    localparam int IN         = 4;
    localparam int OUT        = 3;
    localparam int SETTLE_CYC = 2;
    localparam int ACC_W      = WIDTH * 2 + $clog2(IN);
    localparam int IDX_W      = $clog2(OUT);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] x [0:IN-1];
    logic [ACC_W-1:0] z_in [0:OUT-1];
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             class_valid;
    logic [IDX_W-1:0] class_idx;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [WIDTH-1:0] frame_data [0:IN-1];
    logic [WIDTH-1:0] exp_x [0:IN-1];
    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] fz [0:OUT-1];
    bit               force_z    = 0;
    bit               gap_en     = 0;
    int               bp_beat    = -1;
    int               bp_len     = 0;
    int               reset_beat = -1;

    fc_layer_sequencer #(
        .WIDTH      (WIDTH),
        .IN         (IN),
        .OUT        (OUT),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .x           (x),
        .z_in        (z_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .busy        (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Neuron model: z[k] = (k+1) * sum(x); the sum is unsigned, so the ReLU clamp never bites.
    always_comb begin
        int unsigned s;
        s = 0;
        for (int i = 0; i < IN; i++) s = s + x[i];
        for (int k = 0; k < OUT; k++) z_in[k] = force_z ? fz[k] : ACC_W'(s * (k + 1));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_frame(input int a, input int b, input int c, input int d);
        frame_data[0] = 8'(a);
        frame_data[1] = 8'(b);
        frame_data[2] = 8'(c);
        frame_data[3] = 8'(d);
    endtask

    // Driver: starts at a negedge with the DUT expected in LOAD, ends at the
    // negedge of the first LOAD cycle after CLASS (or after a mid-frame reset).
    task automatic run_frame(output int t_first_o);
        int               k;
        int               guard;
        int               t_last;
        int               s;
        int               exp_cls;
        bit               tog;
        logic [ACC_W-1:0] exp_v [0:OUT-1];
        logic [ACC_W-1:0] best;

        t_first_o = -1;
        t_last    = 0;
        s = 0;
        for (int i = 0; i < IN; i++) s += int'(frame_data[i]);
        for (int b = 0; b < OUT; b++) begin
            exp_v[b] = force_z ? fz[b] : ACC_W'(s * (b + 1));
            exp_q.push_back(exp_v[b]);
        end
        best = '0;
        for (int b = 0; b < OUT; b++) if (exp_v[b] > best) best = exp_v[b];
        exp_cls = -1;
        for (int b = 0; b < OUT; b++) if (exp_cls < 0 && exp_v[b] == best) exp_cls = b;

        k = 0; guard = 0; tog = 1;
        while (k < IN && guard < 100) begin
            if (gap_en) begin
                in_valid = tog;
                tog = !tog;
            end else begin
                in_valid = 1'b1;
            end
            in_data = in_valid ? frame_data[k] : 8'($urandom_range(0, 255));
            if (in_valid && in_ready) begin
                if (k == 0) t_first_o = cyc;
                exp_x[k] = frame_data[k];
                t_last = cyc;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (k < IN) begin
            chk("load_timeout", 32'(k), 32'(IN));
            exp_q.delete();
            return;
        end

        guard = 0;
        while (!out_valid && guard < 20) begin
            chk("settle_in_ready", 32'(in_ready), 0);
            chk("settle_busy", 32'(busy), 1);
            if (gap_en) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            exp_q.delete();
            return;
        end
        chk("first_latency", 32'(cyc - t_last), 32'(SETTLE_CYC + 1));
        for (int i = 0; i < IN; i++) chk("x_frame", 32'(x[i]), 32'(exp_x[i]));

        for (int b = 0; b < OUT; b++) begin
            if (gap_en) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            if (b == bp_beat) begin
                out_ready = 1'b0;
                repeat (bp_len) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(out_valid), 1);
                    chk("bp_data", 32'(out_data), 32'(exp_q[0]));
                    chk("bp_idx", 32'(out_idx), 32'(b));
                end
                out_ready = 1'b1;
            end
            chk("beat_valid", 32'(out_valid), 1);
            chk("beat_data", 32'(out_data), 32'(exp_q[0]));
            chk("beat_idx", 32'(out_idx), 32'(b));
            chk("beat_last", 32'(out_last), 32'(b == OUT - 1));
            void'(exp_q.pop_front());
            @(negedge clk);
            if (b == reset_beat) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_class_valid", 32'(class_valid), 0);
                for (int i = 0; i < IN; i++) chk("rst_x", 32'(x[i]), 0);
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                exp_q.delete();
                return;
            end
        end
        in_valid = 1'b0;

        chk("cls_valid", 32'(class_valid), 1);
        chk("cls_idx", 32'(class_idx), 32'(exp_cls));
        chk("cls_in_ready", 32'(in_ready), 0);
        chk("cls_out_valid", 32'(out_valid), 0);
        for (int i = 0; i < IN; i++) chk("x_retained", 32'(x[i]), 32'(exp_x[i]));
        chk("sb_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        chk("cls_pulse_end", 32'(class_valid), 0);
        chk("cls_hold", 32'(class_idx), 32'(exp_cls));
        chk("load_in_ready", 32'(in_ready), 1);
        chk("load_busy", 32'(busy), 0);
    endtask

    initial begin
        int t_a;
        int t_b;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int b = 0; b < OUT; b++) fz[b] = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_idx", 32'(out_idx), 0);
        chk("reset_out_last", 32'(out_last), 0);
        chk("reset_class_valid", 32'(class_valid), 0);
        chk("reset_class_idx", 32'(class_idx), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < IN; i++) chk("reset_x", 32'(x[i]), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: 10, 20, 30 -> class 2
        set_frame(1, 2, 3, 4);
        run_frame(t_a);

        // Tie on the top value keeps the lower index
        force_z = 1; fz[0] = 7; fz[1] = 7; fz[2] = 3;
        set_frame(9, 8, 7, 6);
        run_frame(t_a);
        force_z = 0;

        // Backpressure on beat 1
        set_frame(1, 2, 3, 4);
        bp_beat = 1; bp_len = 5;
        run_frame(t_a);
        bp_beat = -1;

        // All-zero results
        set_frame(0, 0, 0, 0);
        run_frame(t_a);

        // Gapped input and stray in_valid pulses while busy
        gap_en = 1;
        set_frame(5, 6, 7, 8);
        run_frame(t_a);
        gap_en = 0;

        // Reset during EMIT, then a clean frame
        set_frame(9, 9, 9, 9);
        reset_beat = 0;
        run_frame(t_a);
        reset_beat = -1;
        repeat (3) begin
            chk("post_rst_class_valid", 32'(class_valid), 0);
            chk("post_rst_out_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        set_frame(2, 2, 2, 2);
        run_frame(t_a);

        // Back-to-back frames
        set_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        run_frame(t_a);
        set_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        run_frame(t_b);
        chk("frame_period", 32'(t_b - t_a), 32'(IN + SETTLE_CYC + OUT + 1));

        // Random frames with random gaps, backpressure and forced results
        for (int f = 0; f < 8; f++) begin
            set_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            gap_en  = 1'($urandom_range(0, 1));
            bp_beat = int'($urandom_range(0, OUT)) - 1;
            bp_len  = $urandom_range(1, 4);
            force_z = 1'($urandom_range(0, 1));
            for (int b = 0; b < OUT; b++) fz[b] = ACC_W'($urandom_range(0, 5));
            run_frame(t_a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        gap_en = 0; bp_beat = -1; force_z = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
